// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes over N cycles, then applies the sign in one fix-up cycle.
module seq_multiplier #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]  count_reg;
  logic [N-1:0]   hi_reg;
  logic [N-1:0]   lo_reg;
  logic [N-1:0]   mag_a_reg;
  logic [1:0]     op_reg;
  logic           neg_reg;
  logic           done_reg;
  logic [N-1:0]   result_reg;

  logic           a_neg;
  logic           b_neg;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [N:0]     sum;
  logic [2*N-1:0] product;
  logic [2*N-1:0] fixed;

  // Only rs1 is signed for MULH/MULHSU; only rs2 is signed for MULH.
  always_comb begin
    a_neg   = ((op == 2'b01) || (op == 2'b10)) && a[N-1];
    b_neg   = (op == 2'b01) && b[N-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    sum     = lo_reg[0] ? ({1'b0, hi_reg} + {1'b0, mag_a_reg}) : {1'b0, hi_reg};
    product = {hi_reg, lo_reg};
    fixed   = neg_reg ? -product : product;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = CALC;
      CALC: if (count_reg == CW'(N - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      mag_a_reg  <= '0;
      op_reg     <= 2'b00;
      neg_reg    <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg    <= op;
            mag_a_reg <= a_mag;
            neg_reg   <= a_neg ^ b_neg;
            hi_reg    <= '0;
            lo_reg    <= b_mag;
            count_reg <= '0;
          end
        end
        CALC: begin
          // Carry out of the partial sum shifts into the top of the accumulator.
          {hi_reg, lo_reg} <= {sum, lo_reg[N-1:1]};
          count_reg        <= count_reg + 1'b1;
        end
        FIX: begin
          result_reg <= (op_reg == 2'b00) ? fixed[N-1:0] : fixed[2*N-1:N];
          done_reg   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative shift-add multiplier for the RV32M extension (MUL, MULH, MULHSU, MULHU), placed in the EX stage beside the ALU.
- Each cycle it feeds one N-bit partial-sum addition to the ripple-carry adder datapath, which has a carry-out at bit N, and consumes the N+1-bit sum.
- One multiply takes N+1 cycles, under a start/busy/done handshake with the hazard/stall logic.

Parameters:
- N, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled only when idle.
- op  input  2  00 MUL (low N bits), 01 MULH (signed x signed, high), 10 MULHSU (signed a x unsigned b, high), 11 MULHU (unsigned x unsigned, high).
- a  input  N  multiplicand (rs1).
- b  input  N  multiplier (rs2).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  N  selected half of the 2N-bit product.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, busy=0, done=0, result=0, internal accumulator/counter=0. Takes effect immediately, including mid-operation; the in-flight operation is discarded with no done pulse.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0 latches a, b and op.
  - Signed operands (a for op 01/10, b for op 01) are converted to magnitude; neg = sign(a) XOR sign(b), counting only the signed operands.
  - Accumulator hi=0, lo=|b|; count=0; state->CALC; busy=1.
- CALC (exactly N cycles):
  - If lo[0]=1, compute sum = hi + |a| as an N+1-bit value (carry at bit N). Otherwise sum = {1'b0, hi}.
  - {hi, lo} <= {sum, lo[N-1:1]}, i.e. shift right by one with the carry entering the top.
  - After N iterations, state->FIX.
- FIX (1 cycle):
  - If neg, the 2N-bit product is two's-complement negated.
  - result <= low N bits for op 00, else high N bits.
  - done=1 for this cycle only; busy=0 at the same edge; state->IDLE.
- Latency: done is asserted in the cycle following edge E0+N+1 (N+1 edges after start is accepted). busy is high for cycles E0+1 .. E0+N+1.
- result holds its value until the next FIX. A new start may be accepted in the cycle done is high.
- start while busy=1 is ignored; the operands and op of the in-flight operation are unchanged.
- MUL low half is identical for signed and unsigned operands; the op=00 path must match a*b mod 2^N.
- Most-negative operand (0x80000000): its magnitude 2^(N-1) is representable in N unsigned bits and must produce the exact product.
- Zero operand yields 0 in all ops, with no sign artefact (negating 0 gives 0).
- op, a and b changing after acceptance have no effect.

Test Plan:
- Reset, then op=00, a=7, b=6, start 1 cycle -> busy high for 33 cycles, done pulses once at 33 edges after start, result=0x0000002A.
- op=01, a=b=0x80000000 -> result=0x40000000. Then op=01, a=b=0xFFFFFFFF -> result=0x00000000.
- op=10, a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFF. Then op=11, same operands -> result=0xFFFFFFFE.
- op=00, a=0x12345678, b=0; assert start again with a=5, b=5 at cycle 10 -> second start ignored, result=0x00000000. Then start in the done cycle with a=5, b=5 -> accepted, result=0x00000019.
- Drive rst low at cycle 15 of an op=11 operation -> busy=0, done=0, result=0 immediately. Release rst, run op=00, a=3, b=0xFFFFFFFD -> result=0xFFFFFFF7.
- Random regression: 1000 random (op, a, b) compared against a 64-bit reference model; every operation gets exactly one done pulse, 33 edges after start.
